// File: rtl/dna_fetch.sv
// dna_fetch: bus initiator that reads the 57-bit device DNA from axi_dna.
// On start it reads the high word and repeats the read until the ready
// flag (bit 31) is set, then reads the low word, assembles
// {hi[24:0], lo[31:0]} and presents it with sticky status flags.
//
// Ports:
//   clk_48     in   fabric clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   fetch request, only looked at in IDLE
//   busy       out  high whenever the FSM is not in IDLE
//   done       out  one-cycle pulse at the end of a fetch (ok or error)
//   dna[56:0]  out  last successfully fetched DNA
//   dna_valid  out  dna is valid (sticky, cleared on accepted start)
//   err[1:0]   out  00 ok, 01 poll limit, 10 response timeout (sticky)
//   arvalid    out  read request, exactly one cycle per request
//   araddr     out  address bit 2: 1 = high word, 0 = low word
//   rvalid     in   read response valid
//   rdata[31:0] in  read response data
//   fsm_state  out  current FSM state, for debug/observation
//
// Handshake: arvalid is a single-cycle request with no ready return; the
// responder answers with a single-cycle rvalid some cycles later. Only one
// request is ever outstanding, and rvalid is looked at only while waiting
// for a response (R_HI / R_LO); anywhere else it is ignored.
module dna_fetch #(
  parameter int POLL_GAP    = 64,
  parameter int MAX_POLLS   = 255,
  parameter int RSP_TIMEOUT = 15
) (
  input  logic        clk_48,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [56:0] dna,
  output logic        dna_valid,
  output logic [1:0]  err,
  output logic        arvalid,
  output logic        araddr,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  output logic [2:0]  fsm_state
);

  localparam int GCW = $clog2(POLL_GAP + 1);
  localparam int TCW = $clog2(RSP_TIMEOUT + 1);
  localparam int PCW = (MAX_POLLS > 0) ? $clog2(MAX_POLLS + 1) : 1;
  localparam bit POLL_LIMIT = (MAX_POLLS > 0);

  localparam logic [GCW-1:0] GAP_LOAD = GCW'(POLL_GAP);
  localparam logic [TCW-1:0] T_LAST   = TCW'(RSP_TIMEOUT);
  // Poll count before the increment that would reach MAX_POLLS.
  localparam logic [PCW-1:0] P_LAST   = (MAX_POLLS > 0) ? PCW'(MAX_POLLS - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR_HI = 3'd1,
    S_R_HI  = 3'd2,
    S_GAP   = 3'd3,
    S_AR_LO = 3'd4,
    S_R_LO  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t state, state_next;

  logic [GCW-1:0] gap_cnt;
  logic [TCW-1:0] tmo_cnt;
  logic [PCW-1:0] poll_cnt;
  logic [24:0]    hold;

  logic       clr_flags, clr_tmo, inc_tmo, inc_poll, load_gap, dec_gap;
  logic       latch_hi, wr_dna, set_err;
  logic [1:0] err_code;

  // Reserved high-word bits carry no information.
  logic unused_rdata;
  assign unused_rdata = ^rdata[30:25];

  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr_flags  = 1'b0;
    clr_tmo    = 1'b0;
    inc_tmo    = 1'b0;
    inc_poll   = 1'b0;
    load_gap   = 1'b0;
    dec_gap    = 1'b0;
    latch_hi   = 1'b0;
    wr_dna     = 1'b0;
    set_err    = 1'b0;
    err_code   = 2'b00;
    case (state)
      S_IDLE: begin
        if (start) begin
          clr_flags  = 1'b1;
          state_next = S_AR_HI;
        end
      end
      S_AR_HI: begin
        clr_tmo    = 1'b1;
        state_next = S_R_HI;
      end
      S_R_HI: begin
        if (rvalid) begin
          if (rdata[31]) begin
            latch_hi   = 1'b1;
            state_next = S_AR_LO;
          end else if (POLL_LIMIT && (poll_cnt == P_LAST)) begin
            set_err    = 1'b1;
            err_code   = 2'b01;
            state_next = S_FIN;
          end else begin
            // Unlimited polling keeps the counter frozen so it cannot wrap.
            inc_poll   = POLL_LIMIT;
            load_gap   = 1'b1;
            state_next = S_GAP;
          end
        end else if (tmo_cnt == T_LAST) begin
          set_err    = 1'b1;
          err_code   = 2'b10;
          state_next = S_FIN;
        end else begin
          inc_tmo = 1'b1;
        end
      end
      S_GAP: begin
        dec_gap = 1'b1;
        if (gap_cnt == GCW'(1)) state_next = S_AR_HI;
      end
      S_AR_LO: begin
        clr_tmo    = 1'b1;
        state_next = S_R_LO;
      end
      S_R_LO: begin
        if (rvalid) begin
          wr_dna     = 1'b1;
          state_next = S_FIN;
        end else if (tmo_cnt == T_LAST) begin
          set_err    = 1'b1;
          err_code   = 2'b10;
          state_next = S_FIN;
        end else begin
          inc_tmo = 1'b1;
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      poll_cnt  <= '0;
      hold      <= '0;
      dna       <= '0;
      dna_valid <= 1'b0;
      err       <= 2'b00;
    end else begin
      if (clr_flags) begin
        dna_valid <= 1'b0;
        err       <= 2'b00;
        poll_cnt  <= '0;
      end
      if (inc_poll) poll_cnt <= poll_cnt + 1'b1;
      if (clr_tmo)      tmo_cnt <= '0;
      else if (inc_tmo) tmo_cnt <= tmo_cnt + 1'b1;
      if (load_gap)     gap_cnt <= GAP_LOAD;
      else if (dec_gap) gap_cnt <= gap_cnt - 1'b1;
      if (latch_hi) hold <= rdata[24:0];
      // dna only changes from a hi+lo pair of the same fetch.
      if (wr_dna) begin
        dna       <= {hold, rdata};
        dna_valid <= 1'b1;
      end
      if (set_err) err <= err_code;
    end
  end

  // Outputs decode the state register directly so reset drops them at once.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign arvalid   = (state == S_AR_HI) || (state == S_AR_LO);
  assign araddr    = (state == S_AR_HI);
  assign fsm_state = state;

endmodule

// File: tb/tb_dna_fetch.sv
// Testbench for dna_fetch: a responder that plays back planned responses,
// a reference model that predicts each fetch outcome from the protocol's
// timing rules, and a monitor that checks every done pulse.
module tb_dna_fetch;

  localparam int GAP = 4;
  localparam int MP  = 4;
  localparam int T   = 15;
  localparam int W   = 84;  // {latency16, requests8, err2, dna_valid1, dna57}

  logic        clk_48 = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [56:0] dna;
  logic        dna_valid;
  logic [1:0]  err;
  logic        arvalid;
  logic        araddr;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [2:0]  fsm_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int arv_cnt = 0;

  logic [56:0] ref_dna  = '0;
  logic [1:0]  last_err = 2'b00;
  logic        last_dv  = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [40:0]  rsp_q[$];  // {addr, latency8, data32}

  dna_fetch #(
    .POLL_GAP   (GAP),
    .MAX_POLLS  (MP),
    .RSP_TIMEOUT(T)
  ) dut (
    .clk_48   (clk_48),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .dna      (dna),
    .dna_valid(dna_valid),
    .err      (err),
    .arvalid  (arvalid),
    .araddr   (araddr),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #10 clk_48 = ~clk_48;
  always @(posedge clk_48) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end
  endtask

  task automatic report();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // ---------------- responder ----------------
  int          rsp_wait = 0;
  logic [31:0] rsp_data = '0;
  logic [40:0] ent;

  always @(negedge clk_48) begin
    rvalid = 1'b0;
    rdata  = $urandom;  // junk while not valid
    if (rst) begin
      rsp_wait = 0;
    end else if (rsp_wait > 0) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        rvalid = 1'b1;
        rdata  = rsp_data;
      end
    end
    if (!rst && arvalid) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_arvalid", 64'(arvalid), 64'd0);
      end else begin
        ent = rsp_q.pop_front();
        check("araddr", 64'(araddr), 64'(ent[40]));
        rsp_wait = int'(ent[39:32]);
        rsp_data = ent[31:0];
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic         prev_arv = 1'b0;
  logic [W-1:0] e;

  always @(negedge clk_48) begin
    if (rst) begin
      arv_cnt  = 0;
      prev_arv = 1'b0;
    end else begin
      if (arvalid) begin
        arv_cnt++;
        check("arvalid_single_cycle", 64'(prev_arv), 64'd0);
      end
      prev_arv = arvalid;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_latency", 64'(cyc - start_cyc + 1), 64'(e[83:68]));
          check("request_count", 64'(arv_cnt), 64'(e[67:60]));
          check("err", 64'(err), 64'(e[59:58]));
          check("dna_valid", 64'(dna_valid), 64'(e[57]));
          check("dna", 64'(dna), 64'(e[56:0]));
          check("busy_at_done", 64'(busy), 64'd1);
        end
        arv_cnt = 0;
      end
    end
  end

  // ---------------- reference model + driver ----------------
  // mode: 0 random latency, 1 latency 1, 2 latency T+1 (last accepted cycle)
  function automatic int pick_lat(input int idx, input int to_idx, input int mode);
    if (idx == to_idx) return T + 2 + int'($urandom_range(0, 4));
    if (mode == 1) return 1;
    if (mode == 2) return T + 1;
    return int'($urandom_range(1, T + 1));
  endfunction

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk_48);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done in 3000 cycles, required a done pulse");
      report();
    end
  endtask

  task automatic run_fetch(input int n_nr, input logic [56:0] d, input int to_idx,
                           input int mode, input bit pulse_busy);
    int          t;
    int          req;
    int          polls;
    int          lat;
    bit          hi_ok;
    bit          ok;
    logic [1:0]  e_err;
    logic [31:0] w;
    t = 0; req = 0; polls = 0; hi_ok = 1'b0; ok = 1'b0; e_err = 2'b00;
    // A request costs 1 cycle plus its latency; a not-ready poll adds GAP;
    // a timeout costs T+2 from the request; done follows one cycle later.
    while (1'b1) begin
      lat = pick_lat(req, to_idx, mode);
      if (polls < n_nr) w = {1'b0, 6'($urandom), 25'($urandom)};
      else              w = {1'b1, 6'($urandom), d[56:32]};
      rsp_q.push_back({1'b1, 8'(lat), w});
      req++;
      if (lat > T + 1) begin t += T + 2; e_err = 2'b10; break; end
      t += 1 + lat;
      if (polls < n_nr) begin
        polls++;
        if (polls == MP) begin e_err = 2'b01; break; end
        t += GAP;
      end else begin
        hi_ok = 1'b1;
        break;
      end
    end
    if (hi_ok) begin
      lat = pick_lat(req, to_idx, mode);
      rsp_q.push_back({1'b0, 8'(lat), d[31:0]});
      req++;
      if (lat > T + 1) begin
        t += T + 2;
        e_err = 2'b10;
      end else begin
        t += 1 + lat;
        ok = 1'b1;
      end
    end
    if (ok) ref_dna = d;
    last_err = e_err;
    last_dv  = ok;
    exp_q.push_back({16'(t + 1), 8'(req), e_err, ok, ref_dna});

    @(negedge clk_48);
    start = 1'b1;
    @(posedge clk_48);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", 64'(busy), 64'd1);
    check("dna_valid_cleared", 64'(dna_valid), 64'd0);
    check("err_cleared", 64'(err), 64'd0);
    if (pulse_busy) begin
      @(negedge clk_48);
      start = 1'b1;
      @(negedge clk_48);
      start = 1'b0;
    end
    wait_done();
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk_48);
    check("hold_dna", 64'(dna), 64'(ref_dna));
    check("hold_dna_valid", 64'(dna_valid), 64'(last_dv));
    check("hold_err", 64'(err), 64'(last_err));
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic reset_mid();
    rsp_q.push_back({1'b1, 8'd1, {1'b1, 6'd0, 25'h0abcdef}});
    rsp_q.push_back({1'b0, 8'd1, 32'h1234_5678});
    @(negedge clk_48);
    start = 1'b1;
    @(posedge clk_48);
    #1;
    start = 1'b0;
    @(posedge clk_48);
    @(posedge clk_48);
    #2;
    check("lo_request_up", 64'(arvalid), 64'd1);
    check("lo_request_addr", 64'(araddr), 64'd0);
    rst = 1'b1;
    #1;
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dna", 64'(dna), 64'd0);
    check("rst_dna_valid", 64'(dna_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    repeat (3) @(negedge clk_48);
    rst = 1'b0;
    rsp_q.delete();
    ref_dna  = '0;
    last_dv  = 1'b0;
    last_err = 2'b00;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk_48);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dna", 64'(dna), 64'd0);
    check("reset_dna_valid", 64'(dna_valid), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_arvalid", 64'(arvalid), 64'd0);
    check("reset_araddr", 64'(araddr), 64'd0);
    rst = 1'b0;
    @(negedge clk_48);

    // Ready on first poll.
    run_fetch(0, 57'h1_2345_6789_ABCD_EF, -1, 1, 1'b0);
    settle(6);
    // Never ready: poll limit, dna keeps prior value.
    run_fetch(100, {25'($urandom), 32'($urandom)}, -1, 1, 1'b0);
    settle(6);
    // Ready after three not-ready polls.
    run_fetch(3, {25'($urandom), 32'($urandom)}, -1, 1, 1'b0);
    settle(6);
    // Silent lo read; late response lands after done.
    run_fetch(0, {25'($urandom), 32'($urandom)}, 1, 1, 1'b0);
    settle(12);
    // Silent hi read with random latencies.
    run_fetch(0, {25'($urandom), 32'($urandom)}, 0, 0, 1'b0);
    settle(12);
    // Responses on the last cycle before timeout.
    run_fetch(1, {25'($urandom), 32'($urandom)}, -1, 2, 1'b0);
    settle(4);
    // start while busy is ignored; start right after done is accepted.
    run_fetch(0, {25'($urandom), 32'($urandom)}, -1, 0, 1'b1);
    run_fetch(1, {25'($urandom), 32'($urandom)}, -1, 0, 1'b0);
    settle(4);
    // Reset between hi response and lo request, then a normal fetch.
    reset_mid();
    check("no_pending_expect", 64'(exp_q.size()), 64'd0);
    run_fetch(0, {25'($urandom), 32'($urandom)}, -1, 0, 1'b0);
    settle(4);

    for (int i = 0; i < 12; i++) begin
      int n_nr;
      int to_idx;
      n_nr   = int'($urandom_range(0, 5));
      to_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n_nr + 1)) : -1;
      run_fetch(n_nr, {25'($urandom), 32'($urandom)}, to_idx, 0, 1'b0);
      settle(12);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    report();
  end

endmodule

// File: doc/dna_fetch.md
# dna_fetch

Bus initiator that retrieves the 57-bit device DNA from the `axi_dna` read responder on the 48 MHz fabric clock. On `start` it polls the responder's high word until the DNA-ready flag is set, then reads the low word, assembles the 57-bit value and presents it with status flags. It sits between `axi_dna` and any consumer that needs the device ID, such as a USB descriptor serial-number generator or a licence check, so those consumers do not drive the read channel themselves.

## Interface

Parameters:

- `POLL_GAP`, default 64: idle cycles between a not-ready high-word read and the next one, 1..65535.
- `MAX_POLLS`, default 255: not-ready high-word reads tolerated before error. 0 means unlimited.
- `RSP_TIMEOUT`, default 15: cycles allowed from `arvalid` to `rvalid` before error, 1..255.

Ports:

- `clk_48` input 1: sole clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a fetch. Sampled only in IDLE.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a fetch ends, on success or error.
- `dna` output 57: last successfully fetched DNA. Holds its value until the next success.
- `dna_valid` output 1: `dna` is valid. Sticky; cleared on accepted `start`.
- `err` output 2: 00 ok, 01 poll limit exhausted, 10 response timeout. Sticky; cleared on accepted `start`.
- `arvalid` output 1: read request to `axi_dna`. Held for exactly one cycle per request.
- `araddr` output 1 (bit [2:2]): 1 selects the high word, 0 the low word.
- `rvalid` input 1: read response valid from `axi_dna`.
- `rdata` input 32: read data. High word layout: bit31 = ready, bits30:25 = 0, bits24:0 = dna[56:32]. Low word: dna[31:0].

## Operation

States:

- IDLE: on `start`, clear `dna_valid`, clear `err`, clear the poll count, go to AR_HI.
- AR_HI: `arvalid`=1, `araddr`=1, clear the timeout counter, go to R_HI.
- R_HI, on `rvalid`:
  - If `rdata[31]`=1: latch `rdata[24:0]` into a high holding register, go to AR_LO.
  - If `rdata[31]`=0: increment the poll count. If `MAX_POLLS`≠0 and the count equals `MAX_POLLS`, set `err`=01 and go to FIN. Otherwise load the gap counter with `POLL_GAP` and go to GAP.
- GAP: decrement the gap counter; at 1, go to AR_HI.
- AR_LO: `arvalid`=1, `araddr`=0, clear the timeout counter, go to R_LO.
- R_LO, on `rvalid`: `dna` <= {hold[24:0], `rdata`}, `dna_valid`=1, go to FIN.
- R_HI / R_LO timeout: every cycle without `rvalid` increments the timeout counter. When it reaches `RSP_TIMEOUT`, set `err`=10 and go to FIN. `dna` is unchanged.
- FIN: `done`=1 for this single cycle, go to IDLE.

Rules:

- At most one request is outstanding. `arvalid` is never asserted outside AR_HI and AR_LO.
- `rvalid` outside R_HI and R_LO is ignored.
- `rdata[30:25]` is ignored.
- A late `rvalid` after a timeout is ignored.
- `start` while busy is ignored and not queued.
- `dna` is only written from a complete hi+lo pair within a single fetch. A partial fetch never alters it.
- Counter widths are sized from their parameters. No wrap-around is possible: poll count ≤ `MAX_POLLS`, timeout ≤ `RSP_TIMEOUT`.

## Timing

- Reset values: `busy`=0, `done`=0, `dna`=0, `dna_valid`=0, `err`=00, `arvalid`=0, `araddr`=0, state IDLE.
- Reset mid-fetch clears all state and outputs asynchronously. `arvalid` drops the same instant, and no `done` pulse is produced.
- Ready-on-first-poll case, with `start` seen at edge k:
  - `arvalid`/`araddr`=1 in cycle k+1.
  - `axi_dna` returns `rvalid` in k+2.
  - `arvalid`/`araddr`=0 in k+3.
  - `rvalid` in k+4.
  - `done`=1, `dna_valid`=1, updated `dna` in k+5.
  - `busy` is high k+1..k+5.
- Each not-ready poll adds 2 + `POLL_GAP` cycles.
- Timeout: `done` is asserted `RSP_TIMEOUT`+2 cycles after the unanswered `arvalid`.
- `start` asserted in the cycle after FIN (IDLE) is accepted.

## Test plan

- Responder ready immediately, DNA 0x1_2345_6789_ABCD_EF: `start` → `arvalid` at k+1 (addr 1) and k+3 (addr 0); `done`+`dna_valid` at k+5; `dna`=0x1_2345_6789_ABCD_EF; `err`=00.
- Ready after 3 not-ready polls, `POLL_GAP`=4: exactly 5 `arvalid` pulses, issued at k+1, k+7, k+13, k+19 (hi) and k+21 (lo); `done` at k+23.
- `MAX_POLLS`=2, never ready: two hi reads, then `done` with `err`=01, `dna_valid`=0, and `dna` keeping its prior value 0x1_2345_6789_ABCD_EF.
- Responder silent on the lo read, `RSP_TIMEOUT`=15: `done` 17 cycles after the lo `arvalid`, `err`=10. A late `rvalid` injected afterwards leaves all outputs unchanged.
- `start` pulsed while busy and again in the cycle after `done`: the first is ignored, and the second launches a new fetch that clears `dna_valid` and `err` at the next edge.
- `rst` asserted between the hi response and the lo request: `arvalid` is low immediately, all outputs are at reset values, and no `done` pulse occurs. The next `start` completes normally.
